// File: rtl/cr16_pkg.sv
// cr16_pkg -- constants shared by the CR16 ALU, decoder and PSR/condition block.
//   FLAG_*     : bit index of each status flag inside the 5-bit PSR / status vector
//   NUM_FLAGS  : width of the PSR
//   cond_e     : the 4-bit condition codes
package cr16_pkg;

  localparam int FLAG_C    = 0;
  localparam int FLAG_L    = 1;
  localparam int FLAG_F    = 2;
  localparam int FLAG_Z    = 3;
  localparam int FLAG_N    = 4;
  localparam int NUM_FLAGS = 5;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_HI = 4'b0100,
    COND_LS = 4'b0101,
    COND_GT = 4'b0110,
    COND_LE = 4'b0111,
    COND_FS = 4'b1000,
    COND_FC = 4'b1001,
    COND_LO = 4'b1010,
    COND_HS = 4'b1011,
    COND_LT = 4'b1100,
    COND_GE = 4'b1101,
    COND_UC = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// cond_eval -- purely combinational decode of a condition code against flags.
//   flags : effective PSR flags (C,L,F,Z,N at cr16_pkg indices)
//   code  : 4-bit condition code
//   taken : 1 when the condition holds
module cond_eval
  import cr16_pkg::*;
(
  input  logic [NUM_FLAGS-1:0] flags,
  input  logic [3:0]           code,
  output logic                 taken
);

  logic c, l, f, z, n;

  assign c = flags[FLAG_C];
  assign l = flags[FLAG_L];
  assign f = flags[FLAG_F];
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(code))
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_HI: taken = l;
      COND_LS: taken = !l;
      COND_GT: taken = n;
      COND_LE: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_LO: taken = !l && !z;
      COND_HS: taken = l || z;
      COND_LT: taken = !n && !z;
      COND_GE: taken = n || z;
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond.sv
// psr_cond -- CR16 processor status register, condition evaluation and an
// optional PSR shadow stack (enabled by defining CR16_PSR_STACK_EN).
//   I_CLK, I_NRESET              : clock, asynchronous active-low reset
//   I_FLAG_WE/I_FLAG_MASK/I_STATUS: masked write of ALU status into the PSR
//   I_COND_VALID/I_COND          : condition request, result one cycle later
//   I_PUSH/I_POP/I_ERR_CLR       : shadow stack push/pop, sticky error clear
//   O_PSR                        : committed flags
//   O_COND_VALID/O_TAKEN         : registered evaluation result
//   O_STACK_*                    : stack occupancy and sticky overflow/underflow
// Without CR16_PSR_STACK_EN the stack ports are kept but tied off.
module psr_cond
  import cr16_pkg::*;
#(
  parameter int P_STACK_DEPTH = 4
) (
  input  logic                                 I_CLK,
  input  logic                                 I_NRESET,
  input  logic                                 I_FLAG_WE,
  input  logic [NUM_FLAGS-1:0]                 I_FLAG_MASK,
  input  logic [NUM_FLAGS-1:0]                 I_STATUS,
  input  logic                                 I_COND_VALID,
  input  logic [3:0]                           I_COND,
  input  logic                                 I_PUSH,
  input  logic                                 I_POP,
  input  logic                                 I_ERR_CLR,
  output logic [NUM_FLAGS-1:0]                 O_PSR,
  output logic                                 O_COND_VALID,
  output logic                                 O_TAKEN,
  output logic [$clog2(P_STACK_DEPTH+1)-1:0]   O_STACK_COUNT,
  output logic                                 O_STACK_FULL,
  output logic                                 O_STACK_EMPTY,
  output logic                                 O_STACK_OVF,
  output logic                                 O_STACK_UNF
);

  localparam int CW = $clog2(P_STACK_DEPTH + 1);

  logic [NUM_FLAGS-1:0] psr_reg, psr_next;
  logic [NUM_FLAGS-1:0] flags_eff;
  logic                 cond_valid_reg, taken_reg;
  logic                 taken_comb;

  // Effective flags: committed PSR with this cycle's masked write forwarded.
  // This is also the PSR's next value unless a pop overrides it.
  generate
    for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_fwd
      assign flags_eff[gi] = (I_FLAG_WE && I_FLAG_MASK[gi]) ? I_STATUS[gi] : psr_reg[gi];
    end
  endgenerate

  cond_eval u_cond_eval (
    .flags (flags_eff),
    .code  (I_COND),
    .taken (taken_comb)
  );

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      psr_reg        <= '0;
      cond_valid_reg <= 1'b0;
      taken_reg      <= 1'b0;
    end else begin
      psr_reg        <= psr_next;
      cond_valid_reg <= I_COND_VALID;
      if (I_COND_VALID) taken_reg <= taken_comb;
    end
  end

  assign O_PSR        = psr_reg;
  assign O_COND_VALID = cond_valid_reg;
  assign O_TAKEN      = taken_reg;

`ifdef CR16_PSR_STACK_EN
  localparam int AW = (P_STACK_DEPTH > 1) ? $clog2(P_STACK_DEPTH) : 1;

  logic [CW-1:0]        count_reg, count_next;
  logic                 ovf_reg, unf_reg;
  logic [NUM_FLAGS-1:0] stack_mem [P_STACK_DEPTH];
  logic                 full, empty;
  logic                 push_ok, pop_ok, ovf_set, unf_set;
  logic [CW-1:0]        top_idx;

  assign full  = (count_reg == CW'(P_STACK_DEPTH));
  assign empty = (count_reg == '0);

  // Simultaneous push and pop cancel each other: no stack change, no error.
  assign push_ok = I_PUSH && !I_POP && !full;
  assign pop_ok  = I_POP && !I_PUSH && !empty;
  assign ovf_set = I_PUSH && !I_POP && full;
  assign unf_set = I_POP && !I_PUSH && empty;
  assign top_idx = count_reg - CW'(1);

  always_comb begin
    psr_next   = flags_eff;
    count_next = count_reg;
    if (push_ok) count_next = count_reg + CW'(1);
    if (pop_ok) begin
      // Pop wins over the same-cycle flag write.
      psr_next   = stack_mem[top_idx[AW-1:0]];
      count_next = top_idx;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      // A new error in the clear cycle takes priority over the clear.
      if (ovf_set)        ovf_reg <= 1'b1;
      else if (I_ERR_CLR) ovf_reg <= 1'b0;
      if (unf_set)        unf_reg <= 1'b1;
      else if (I_ERR_CLR) unf_reg <= 1'b0;
    end
  end

  // Entry contents need no reset; push stores the pre-write committed PSR.
  always_ff @(posedge I_CLK) begin
    if (push_ok) stack_mem[count_reg[AW-1:0]] <= psr_reg;
  end

  assign O_STACK_COUNT = count_reg;
  assign O_STACK_FULL  = full;
  assign O_STACK_EMPTY = empty;
  assign O_STACK_OVF   = ovf_reg;
  assign O_STACK_UNF   = unf_reg;
`else
  logic unused_stack_in;

  assign psr_next        = flags_eff;
  assign unused_stack_in = ^{I_PUSH, I_POP, I_ERR_CLR};
  assign O_STACK_COUNT   = '0;
  assign O_STACK_FULL    = 1'b0;
  assign O_STACK_EMPTY   = 1'b1;
  assign O_STACK_OVF     = 1'b0;
  assign O_STACK_UNF     = 1'b0;
`endif

endmodule

// File: tb/tb_psr_cond.sv
// tb_psr_cond -- directed self-checking bench for psr_cond (depth 4).
// Stack checks depend on whether CR16_PSR_STACK_EN is defined for the build.
module tb_psr_cond;

  logic       clk;
  logic       rst_n;
  logic       flag_we;
  logic [4:0] flag_mask;
  logic [4:0] status;
  logic       cond_valid;
  logic [3:0] cond;
  logic       push, pop, err_clr;
  logic [4:0] psr;
  logic       o_cond_valid, o_taken;
  logic [2:0] stack_count;
  logic       stack_full, stack_empty, stack_ovf, stack_unf;

  int n_cmp;
  int n_fail;

  // Expected taken for codes 0..15 against PSR=00010 (L=1) and PSR=01000 (Z=1).
  bit exp_l [16] = '{0,1,0,1,1,0,0,1,0,1,0,1,1,0,1,0};
  bit exp_z [16] = '{1,0,0,1,0,1,0,1,0,1,0,1,0,1,1,0};

  psr_cond #(.P_STACK_DEPTH(4)) dut (
    .I_CLK         (clk),
    .I_NRESET      (rst_n),
    .I_FLAG_WE     (flag_we),
    .I_FLAG_MASK   (flag_mask),
    .I_STATUS      (status),
    .I_COND_VALID  (cond_valid),
    .I_COND        (cond),
    .I_PUSH        (push),
    .I_POP         (pop),
    .I_ERR_CLR     (err_clr),
    .O_PSR         (psr),
    .O_COND_VALID  (o_cond_valid),
    .O_TAKEN       (o_taken),
    .O_STACK_COUNT (stack_count),
    .O_STACK_FULL  (stack_full),
    .O_STACK_EMPTY (stack_empty),
    .O_STACK_OVF   (stack_ovf),
    .O_STACK_UNF   (stack_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flag_we = 0; flag_mask = '0; status = '0;
    cond_valid = 0; cond = '0;
    push = 0; pop = 0; err_clr = 0;
  endtask

  task automatic write_psr(input logic [4:0] v);
    flag_we = 1; flag_mask = 5'b11111; status = v;
    step();
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_psr",   8'(psr), 8'h00);
    check("rst_cv",    8'(o_cond_valid), 8'h0);
    check("rst_taken", 8'(o_taken), 8'h0);
    check("rst_count", 8'(stack_count), 8'h0);
    check("rst_empty", 8'(stack_empty), 8'h1);
    check("rst_full",  8'(stack_full), 8'h0);
    check("rst_ovf",   8'(stack_ovf), 8'h0);
    check("rst_unf",   8'(stack_unf), 8'h0);
    rst_n = 1'b1;
    step();
    $display("reset released");

    // Z set, then EQ / NE.
    write_psr(5'b01000);
    check("wr_psr", 8'(psr), 8'h08);
    cond_valid = 1; cond = 4'b0000;
    step();
    check("eq_cv", 8'(o_cond_valid), 8'h1);
    check("eq_taken", 8'(o_taken), 8'h1);
    $display("EQ psr=%b taken=%b", psr, o_taken);
    cond = 4'b0001;
    step();
    check("ne_taken", 8'(o_taken), 8'h0);
    $display("NE psr=%b taken=%b", psr, o_taken);
    cond = 4'b1110;
    step();
    cond_valid = 0; cond = 4'b1111;
    step();
    check("hold_cv", 8'(o_cond_valid), 8'h0);
    check("hold_taken", 8'(o_taken), 8'h1);
    $display("idle cv=%b taken=%b", o_cond_valid, o_taken);

    // Forwarding of a same-cycle masked write.
    write_psr(5'b00000);
    flag_we = 1; flag_mask = 5'b00001; status = 5'b00001;
    cond_valid = 1; cond = 4'b0010;
    step();
    idle_inputs();
    check("fwd_cs", 8'(o_taken), 8'h1);
    check("fwd_psr", 8'(psr), 8'h01);
    $display("CS forwarded taken=%b psr=%b", o_taken, psr);

    // Partial-mask write keeps other bits; zero mask leaves PSR unchanged.
    flag_we = 1; flag_mask = 5'b10000; status = 5'b11110;
    step();
    idle_inputs();
    check("part_mask", 8'(psr), 8'h11);
    flag_we = 1; flag_mask = 5'b00000; status = 5'b11111;
    step();
    idle_inputs();
    check("mask0", 8'(psr), 8'h11);
    $display("mask0 write psr=%b", psr);

    // Sweep all codes against L=1 and Z=1.
    write_psr(5'b00010);
    for (int c = 0; c < 16; c++) begin
      cond_valid = 1; cond = 4'(c);
      step();
      check($sformatf("sweepL_%0d", c), 8'(o_taken), 8'(exp_l[c]));
      $display("psr=00010 code=%b taken=%b", cond, o_taken);
    end
    idle_inputs();
    write_psr(5'b01000);
    for (int c = 0; c < 16; c++) begin
      cond_valid = 1; cond = 4'(c);
      step();
      check($sformatf("sweepZ_%0d", c), 8'(o_taken), 8'(exp_z[c]));
      $display("psr=01000 code=%b taken=%b", cond, o_taken);
    end
    idle_inputs();
    step();

`ifdef CR16_PSR_STACK_EN
    // Five pushes of distinct PSRs into a depth-4 stack.
    for (int i = 0; i < 5; i++) begin
      write_psr(5'(1 << i));
      push = 1;
      step();
      idle_inputs();
      $display("push %0d psr=%b count=%0d ovf=%b", i, psr, stack_count, stack_ovf);
    end
    check("push_count", 8'(stack_count), 8'h4);
    check("push_full", 8'(stack_full), 8'h1);
    check("push_ovf", 8'(stack_ovf), 8'h1);
    check("push_unf", 8'(stack_unf), 8'h0);
    check("push_psr", 8'(psr), 8'h10);
    for (int i = 3; i >= 0; i--) begin
      pop = 1;
      step();
      idle_inputs();
      check($sformatf("pop_%0d", i), 8'(psr), 8'(1 << i));
      $display("pop psr=%b count=%0d", psr, stack_count);
    end
    check("pop_empty", 8'(stack_empty), 8'h1);
    pop = 1;
    step();
    idle_inputs();
    check("unf_set", 8'(stack_unf), 8'h1);
    check("unf_psr", 8'(psr), 8'h01);
    check("unf_count", 8'(stack_count), 8'h0);
    $display("pop on empty unf=%b psr=%b", stack_unf, psr);

    // Build count=2 with entries 5, 6, then PSR=7.
    write_psr(5'd5); push = 1; step(); idle_inputs();
    write_psr(5'd6); push = 1; step(); idle_inputs();
    write_psr(5'd7);
    push = 1; pop = 1;
    step();
    idle_inputs();
    check("pp_count", 8'(stack_count), 8'h2);
    check("pp_psr", 8'(psr), 8'h07);
    $display("push+pop count=%0d psr=%b", stack_count, psr);
    pop = 1; flag_we = 1; flag_mask = 5'b11111; status = 5'b11111;
    step();
    idle_inputs();
    check("popwr_psr", 8'(psr), 8'h06);
    check("popwr_count", 8'(stack_count), 8'h1);
    $display("pop+write psr=%b", psr);
    err_clr = 1;
    step();
    idle_inputs();
    check("clr_ovf", 8'(stack_ovf), 8'h0);
    check("clr_unf", 8'(stack_unf), 8'h0);
    $display("err_clr ovf=%b unf=%b", stack_ovf, stack_unf);
    pop = 1; step(); idle_inputs();
    pop = 1; err_clr = 1;
    step();
    idle_inputs();
    check("clr_vs_unf", 8'(stack_unf), 8'h1);
    $display("pop empty with err_clr unf=%b", stack_unf);
`else
    push = 1;
    step();
    check("nostk_empty", 8'(stack_empty), 8'h1);
    check("nostk_count", 8'(stack_count), 8'h0);
    check("nostk_full", 8'(stack_full), 8'h0);
    check("nostk_ovf", 8'(stack_ovf), 8'h0);
    push = 0; pop = 1;
    step();
    idle_inputs();
    check("nostk_unf", 8'(stack_unf), 8'h0);
    check("nostk_psr", 8'(psr), 8'h08);
    $display("no stack: push/pop empty=%b psr=%b", stack_empty, psr);
`endif

    // Reset between a request and its result.
    write_psr(5'b01000);
    cond_valid = 1; cond = 4'b1110;
    step();
    check("pre_rst_cv", 8'(o_cond_valid), 8'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cv", 8'(o_cond_valid), 8'h0);
    check("mid_rst_taken", 8'(o_taken), 8'h0);
    check("mid_rst_psr", 8'(psr), 8'h00);
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();
    check("post_rst_cv", 8'(o_cond_valid), 8'h0);
    step();
    check("post_rst_cv2", 8'(o_cond_valid), 8'h0);
    $display("reset mid-flight cv=%b", o_cond_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
